set_assoc_cache: RTL and testbench

- Parametrised N-way set-associative data cache between the CPU load/store stage and a variable-latency word memory.
- Policies: one word per line; write-through, no-write-allocate; FIFO replacement per set.
- Replaces the fixed 2-way, single-cycle-memory cache: adds a request/done handshake to the CPU, a request/ack handshake to memory, a flush, and a debug read port.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_fifo_repl.sv | 51 +++++
 rtl/set_assoc_cache.sv | 257 +++++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared types and width helpers for the set-associative cache.
//            Holds the controller state encoding and the clog2-based width
//            functions used to size the index, tag and way-select fields.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_e;

    // Index width; a minimum of one bit keeps vector declarations legal.
    function automatic int idx_width(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - idx_width(sets);
    endfunction

    // A direct-mapped cache still gets a one-bit way select.
    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fifo_repl.sv
`default_nettype none
// ============================================================================
// Module   : cache_fifo_repl
// Purpose  : FIFO replacement state, one round-robin pointer per set. The
//            pointer names the next way to fill and advances only on a fill.
// Ports    : clk, rstn     - clock, async active-low reset
//            set_i         - set being looked up / filled
//            fill_i        - a line is written into set_i at victim_o
//            flush_i       - return every pointer to way 0
//            victim_o      - way to replace in set_i
// Revision : 1.0 - initial release
// ============================================================================
module cache_fifo_repl
    import cache_pkg::*;
#(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 8,
    localparam int IDX_W = idx_width(SETS),
    localparam int WAY_W = way_width(WAYS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] set_i,
    input  logic             fill_i,
    input  logic             flush_i,
    output logic [WAY_W-1:0] victim_o
);

    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] ptr_q [SETS];

    assign victim_o = ptr_q[set_i];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (flush_i) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (fill_i) begin
            // Explicit wrap so a one-way cache keeps its pointer at 0.
            ptr_q[set_i] <= (ptr_q[set_i] == LAST_WAY) ? '0 : ptr_q[set_i] + WAY_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache
// Purpose  : N-way set-associative data cache, one word per line,
//            write-through / no-write-allocate, FIFO replacement per set.
//            CPU side: req/done handshake. Memory side: req/ack handshake
//            with variable latency. Flush invalidates all lines in IDLE.
// Ports    : cpu_*   - CPU request, completion, read data, hit flag
//            flush   - invalidate all lines (IDLE only, wins over cpu_req)
//            mem_*   - word memory request/ack interface
//            dbg_*   - combinational view of one line (set/way select)
// Options  : SET_ASSOC_CACHE_PERF_EN adds saturating 32-bit perf_hits /
//            perf_misses counters, cleared by reset and flush.
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 32,
    parameter  int WAYS   = 2,
    parameter  int SETS   = 8,
    localparam int IDX_W  = idx_width(SETS),
    localparam int TAG_W  = tag_width(ADDR_W, SETS),
    localparam int WAY_W  = way_width(WAYS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [IDX_W-1:0]  dbg_set,
    input  logic [WAY_W-1:0]  dbg_way,
    output logic              dbg_valid,
    output logic [TAG_W-1:0]  dbg_tag,
    output logic [DATA_W-1:0] dbg_data
`ifdef SET_ASSOC_CACHE_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    state_e            state_q;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              lk_hit_q;     // lookup result carried into MEM_WR
    logic              cpu_done_q;
    logic              cpu_hit_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    logic [IDX_W-1:0]  lk_set;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way;
    logic [WAY_W-1:0]  victim;
    logic              fill;
    logic              do_flush;

    // The latched address drives both the lookup and the later fill.
    assign lk_set   = req_addr_q[IDX_W-1:0];
    assign lk_tag   = req_addr_q[ADDR_W-1:IDX_W];
    assign fill     = (state_q == ST_MEM_RD) && mem_ack;
    assign do_flush = (state_q == ST_IDLE) && flush;

    // Fills are the only way a tag enters a set, and only on a miss, so at
    // most one way can match.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    cache_fifo_repl #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_repl (
        .clk      (clk),
        .rstn     (rstn),
        .set_i    (lk_set),
        .fill_i   (fill),
        .flush_i  (do_flush),
        .victim_o (victim)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            lk_hit_q    <= 1'b0;
            cpu_done_q  <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
        end else begin
            cpu_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                        end
                    end else if (cpu_req) begin
                        req_we_q    <= cpu_we;
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                        state_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    lk_hit_q    <= lk_hit;
                    mem_addr_q  <= req_addr_q;
                    mem_wdata_q <= req_wdata_q;
                    if (!req_we_q) begin
                        if (lk_hit) begin
                            cpu_rdata_q <= data_q[lk_set][lk_way];
                            cpu_hit_q   <= 1'b1;
                            cpu_done_q  <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            state_q   <= ST_MEM_RD;
                        end
                    end else begin
                        // Write-through: update a resident copy, never allocate.
                        if (lk_hit) begin
                            data_q[lk_set][lk_way] <= req_wdata_q;
                        end
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        state_q   <= ST_MEM_WR;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ack) begin
                        data_q[lk_set][victim]  <= mem_rdata;
                        tag_q[lk_set][victim]   <= lk_tag;
                        valid_q[lk_set][victim] <= 1'b1;
                        cpu_rdata_q <= mem_rdata;
                        cpu_hit_q   <= 1'b0;
                        cpu_done_q  <= 1'b1;
                        mem_req_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ack) begin
                        cpu_hit_q  <= lk_hit_q;
                        cpu_done_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ready = (state_q == ST_IDLE);
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_hit   = cpu_hit_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign dbg_valid = valid_q[dbg_set][dbg_way];
    assign dbg_tag   = tag_q[dbg_set][dbg_way];
    assign dbg_data  = data_q[dbg_set][dbg_way];

`ifdef SET_ASSOC_CACHE_PERF_EN
    logic        done_d;
    logic        done_hit_d;
    logic [31:0] perf_hits_q;
    logic [31:0] perf_misses_q;

    // Mirrors the cycle in which cpu_done_q is being set, so the counters
    // move on the same edge that the done pulse appears.
    always_comb begin
        done_d     = 1'b0;
        done_hit_d = 1'b0;
        case (state_q)
            ST_LOOKUP: begin
                done_d     = !req_we_q && lk_hit;
                done_hit_d = 1'b1;
            end
            ST_MEM_RD: done_d = mem_ack;
            ST_MEM_WR: begin
                done_d     = mem_ack;
                done_hit_d = lk_hit_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (do_flush) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (done_d) begin
            if (done_hit_d) begin
                if (perf_hits_q != '1) perf_hits_q <= perf_hits_q + 32'd1;
            end else begin
                if (perf_misses_q != '1) perf_misses_q <= perf_misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_cache
// Purpose  : Self-checking bench for set_assoc_cache (WAYS=2, SETS=8). A
//            word memory acks 3 cycles after a request; a line-level model of
//            the cache and a reference copy of memory predict every result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache;

    localparam int WAYS = 2;
    localparam int SETS = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready, cpu_done, cpu_hit;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  dbg_set = '0;
    logic [0:0]  dbg_way = '0;
    logic        dbg_valid;
    logic [4:0]  dbg_tag;
    logic [31:0] dbg_data;
`ifdef SET_ASSOC_CACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    always #5 clk = ~clk;

    set_assoc_cache #(.ADDR_W(8), .DATA_W(32), .WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_set(dbg_set), .dbg_way(dbg_way),
        .dbg_valid(dbg_valid), .dbg_tag(dbg_tag), .dbg_data(dbg_data)
`ifdef SET_ASSOC_CACHE_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Word memory: acks on the third cycle a request has been seen high.
    // ------------------------------------------------------------------
    logic [31:0] mem [256];
    int          lat;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        lat       = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rstn && mem_req) begin
                lat++;
                if (lat == 3) begin
                    lat     = 0;
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                lat = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: lines per set with a fill-order pointer, plus the
    // memory contents the cache should be reflecting.
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [256];
    bit          m_valid [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_ptr   [SETS];
    logic [31:0] m_last;
    int          m_hits, m_misses;

    function automatic int m_find(input int s, input int t);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    task automatic m_invalidate();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    // Expectations shared with the compare process (driver writes only).
    logic        expect_done = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_hit = 1'b0;
    logic [7:0]  cur_addr = '0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_wdata = '0;

    // ------------------------------------------------------------------
    // Compare process: done results and memory-side request properties.
    // ------------------------------------------------------------------
    logic        prev_req = 1'b0, prev_we = 1'b0, prev_ack = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    int          mem_starts = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (cpu_done) begin
                    if (!expect_done) begin
                        chk("done_unexpected", 64'(cpu_done), 64'd0);
                    end else begin
                        chk("done_rdata", 64'(cpu_rdata), 64'(exp_rdata));
                        chk("done_hit", 64'(cpu_hit), 64'(exp_hit));
                    end
                end
                if (mem_req && !prev_req) begin
                    mem_starts++;
                    chk("mem_addr", 64'(mem_addr), 64'(cur_addr));
                    chk("mem_we", 64'(mem_we), 64'(cur_we));
                    if (cur_we) chk("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
                end
                if (mem_req && prev_req && !prev_ack)
                    chk("mem_hold", 64'({mem_we, mem_addr, mem_wdata}),
                        64'({prev_we, prev_addr, prev_wdata}));
            end
            prev_req   = mem_req && rstn;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_ack   = mem_ack;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic txn(input logic we, input logic [7:0] a, input logic [31:0] wd);
        int  s, t, w, lat_n;
        bit  got;
        s = int'(a[2:0]);
        t = int'(a[7:3]);
        w = m_find(s, t);
        exp_hit = (w >= 0);
        if (!we) begin
            exp_rdata = ref_mem[a];
            if (w < 0) begin
                w = m_ptr[s];
                m_valid[s][w] = 1'b1;
                m_tag[s][w]   = t;
                m_data[s][w]  = ref_mem[a];
                m_ptr[s]      = (m_ptr[s] + 1) % WAYS;
            end
        end else begin
            exp_rdata = m_last;
            ref_mem[a] = wd;
            if (w >= 0) m_data[s][w] = wd;
        end
        m_last = exp_rdata;
        if (exp_hit) m_hits++; else m_misses++;
        cur_addr = a; cur_we = we; cur_wdata = wd;
        expect_done = 1'b1;
        chk("ready_before_req", 64'(cpu_ready), 64'd1);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        got = 1'b0;
        lat_n = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat_n++;
            if (cpu_done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 64'(cpu_done), 64'd1);
        else if (exp_hit && !we) chk("read_hit_latency", 64'(lat_n), 64'd2);
        #1;
        expect_done = 1'b0;
    endtask

    task automatic dbg_check(input int s, input int w);
        dbg_set = s[2:0];
        dbg_way = w[0:0];
        #1;
        chk("dbg_valid", 64'(dbg_valid), 64'(m_valid[s][w]));
        if (m_valid[s][w]) begin
            chk("dbg_tag", 64'(dbg_tag), 64'(m_tag[s][w]));
            chk("dbg_data", 64'(dbg_data), 64'(m_data[s][w]));
        end
    endtask

    task automatic dbg_check_all();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) dbg_check(s, w);
    endtask

    task automatic do_flush(input logic with_req, input logic [7:0] a);
        cpu_addr = a; cpu_we = 1'b0; cpu_req = with_req; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; cpu_req = 1'b0;
        m_invalidate();
        chk("ready_after_flush", 64'(cpu_ready), 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int starts0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 + 32'(i);
        m_invalidate();
        m_last = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(cpu_ready), 64'd1);
        chk("rst_done", 64'(cpu_done), 64'd0);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_hit", 64'(cpu_hit), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        dbg_check_all();

        // Miss then hit on 0x05.
        txn(1'b0, 8'h05, '0);
        chk("pin_rd05_data", 64'(cpu_rdata), 64'hA000_0005);
        chk("pin_rd05_hit", 64'(cpu_hit), 64'd0);
        chk("pin_rd05_mem_addr", 64'(mem_addr), 64'h05);
        starts0 = mem_starts;
        txn(1'b0, 8'h05, '0);
        chk("pin_rd05_again_hit", 64'(cpu_hit), 64'd1);
        chk("pin_hit_no_mem_req", 64'(mem_starts), 64'(starts0));

        // FIFO eviction within set 5.
        txn(1'b0, 8'h0D, '0);
        txn(1'b0, 8'h15, '0);
        dbg_check(5, 0);
        chk("pin_evict_tag", 64'(dbg_tag), 64'd2);
        chk("pin_evict_data", 64'(dbg_data), 64'hA000_0015);
        txn(1'b0, 8'h0D, '0);
        chk("pin_rd0d_hit", 64'(cpu_hit), 64'd1);
        txn(1'b0, 8'h05, '0);
        chk("pin_refill05_hit", 64'(cpu_hit), 64'd0);
        dbg_check(5, 1);
        chk("pin_refill05_tag", 64'(dbg_tag), 64'd0);

        // Write hit on a resident line.
        txn(1'b0, 8'h0D, '0);
        txn(1'b1, 8'h0D, 32'h1234_5678);
        chk("pin_wr0d_hit", 64'(cpu_hit), 64'd1);
        chk("pin_wr0d_mem", 64'(mem[8'h0D]), 64'h1234_5678);
        txn(1'b0, 8'h0D, '0);
        chk("pin_rd0d_data", 64'(cpu_rdata), 64'h1234_5678);
        dbg_check(5, 0);
        chk("pin_dbg0d_data", 64'(dbg_data), 64'h1234_5678);

        // Write miss: no allocation.
        txn(1'b1, 8'h25, 32'h0000_0055);
        chk("pin_wr25_hit", 64'(cpu_hit), 64'd0);
        for (int w = 0; w < WAYS; w++) begin
            dbg_set = 3'd5; dbg_way = w[0:0]; #1;
            chk("pin_wr25_noalloc", 64'(dbg_valid && dbg_tag == 5'd4), 64'd0);
        end
        txn(1'b0, 8'h25, '0);
        chk("pin_rd25_data", 64'(cpu_rdata), 64'h55);
        chk("pin_rd25_hit", 64'(cpu_hit), 64'd0);

        // Reset while waiting on a memory read.
        cur_addr = 8'h3A; cur_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h3A;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_mem_req_up", 64'(mem_req), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_mem_req_drop", 64'(mem_req), 64'd0);
        chk("mid_done", 64'(cpu_done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_invalidate();
        m_last = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", 64'(cpu_done), 64'd0);
        end
        #1;
        chk("post_rst_ready", 64'(cpu_ready), 64'd1);
        dbg_check_all();

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) do_flush(1'b0, '0);
            txn(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 63)), $urandom);
            dbg_check(int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WAYS - 1)));
        end
        dbg_check_all();
`ifdef SET_ASSOC_CACHE_PERF_EN
        chk("perf_hits", 64'(perf_hits), 64'(m_hits));
        chk("perf_misses", 64'(perf_misses), 64'(m_misses));
`endif

        // Flush and request together: flush wins.
        txn(1'b0, 8'h11, '0);
        do_flush(1'b1, 8'h11);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_req_ignored", 64'(cpu_done | mem_req), 64'd0);
        end
        dbg_check_all();
`ifdef SET_ASSOC_CACHE_PERF_EN
        chk("perf_hits_flushed", 64'(perf_hits), 64'd0);
        chk("perf_misses_flushed", 64'(perf_misses), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
